// File: rtl/seq_exec_unit_pkg.sv
// Shared definitions for the iterative execute unit: opcode encodings, FSM
// state type and default datapath sizes.
package seq_exec_unit_pkg;

    localparam int WIDTH_DEF   = 8;
    localparam int ADDR_W_DEF  = 3;
    localparam int SHAMT_W_DEF = 3;

    localparam logic [2:0] OP_MUL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/seq_exec_unit_shift.sv
// One-bit shift/rotate step for the iterative shifter; the opcode selects the
// fill behaviour, anything else passes the value through unchanged.
module seq_shift_step
    import seq_exec_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    // single-bit shift selected by opcode
    always_comb begin
        dout_o = din_i;
        case (op_i)
            OP_SLL:  dout_o = {din_i[WIDTH-2:0], 1'b0};
            OP_SRL:  dout_o = {1'b0, din_i[WIDTH-1:1]};
            OP_SRA:  dout_o = {din_i[WIDTH-1], din_i[WIDTH-1:1]};
            OP_ROR:  dout_o = {din_i[0], din_i[WIDTH-1:1]};
            default: dout_o = din_i;
        endcase
    end

endmodule

// File: rtl/seq_exec_unit.sv
// Iterative multi-cycle execute unit: shift-add MUL and bit-serial shifts,
// retiring one register-file write per accepted operation.
module seq_exec_unit
    import seq_exec_unit_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [2:0]        OPCODE,
    input  logic [WIDTH-1:0]  OPERAND1,
    input  logic [WIDTH-1:0]  OPERAND2,
    input  logic [ADDR_W-1:0] DEST_ADDR,
    output logic              BUSY,
    output logic              DONE,
    output logic [WIDTH-1:0]  RESULT,
    output logic [ADDR_W-1:0] WB_ADDR,
    output logic              WB_WRITE,
    output logic              OVF,
    output logic              ILLEGAL
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t                 state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]      dest_q, dest_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   wb_write_q, wb_write_d;
    logic                   illegal_q, illegal_d;
    logic                   ovf_q, ovf_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic [ADDR_W-1:0]      wb_addr_q, wb_addr_d;

    logic [WIDTH-1:0]       shift_s;
    logic [2*WIDTH-1:0]     mul_sum_s;
    logic [CNT_W-1:0]       load_cnt_s;
    logic                   start_legal_s;
    logic [WIDTH-1:0]       step_val_s;
    logic                   step_ovf_s;

    seq_shift_step #(.WIDTH(WIDTH)) u_shift (
        .op_i   (op_q),
        .din_i  (acc_q[WIDTH-1:0]),
        .dout_o (shift_s)
    );

    assign mul_sum_s     = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
    assign start_legal_s = op_is_legal(OPCODE);
    assign step_val_s    = (op_q == OP_MUL) ? mul_sum_s[WIDTH-1:0] : shift_s;
    assign step_ovf_s    = (op_q == OP_MUL) ? (|mul_sum_s[2*WIDTH-1:WIDTH]) : 1'b0;

    // iteration count: full width for MUL, low operand bits for shifts, none if illegal
    always_comb begin
        load_cnt_s = {CNT_W{1'b0}};
        if (OPCODE == OP_MUL) begin
            load_cnt_s = CNT_W'(WIDTH);
        end else if (start_legal_s) begin
            load_cnt_s = CNT_W'(OPERAND2[SHAMT_W-1:0]);
        end else begin
            load_cnt_s = {CNT_W{1'b0}};
        end
    end

    // FSM next state, datapath iteration and retire outputs
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        dest_d     = dest_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        wb_write_d = 1'b0;
        illegal_d  = 1'b0;
        ovf_d      = ovf_q;
        result_d   = result_q;
        wb_addr_d  = wb_addr_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (START) begin
                    op_d     = OPCODE;
                    dest_d   = DEST_ADDR;
                    mcand_d  = {{WIDTH{1'b0}}, OPERAND1};
                    mplier_d = OPERAND2;
                    acc_d    = (OPCODE == OP_MUL) ? {(2*WIDTH){1'b0}}
                                                  : {{WIDTH{1'b0}}, OPERAND1};
                    cnt_d    = load_cnt_s;
                    busy_d   = 1'b1;
                    if (load_cnt_s != {CNT_W{1'b0}}) begin
                        state_d = ST_RUN;
                    end else begin
                        // zero-length shift or illegal opcode retires immediately
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        wb_addr_d  = DEST_ADDR;
                        wb_write_d = start_legal_s;
                        illegal_d  = ~start_legal_s;
                        ovf_d      = 1'b0;
                        if (start_legal_s) begin
                            result_d = OPERAND1;
                        end else begin
                            result_d = result_q;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1'b1);
                if (op_q == OP_MUL) begin
                    acc_d    = mul_sum_s;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end else begin
                    acc_d = {{WIDTH{1'b0}}, shift_s};
                end
                if (cnt_q == CNT_W'(1'b1)) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    wb_write_d = 1'b1;
                    wb_addr_d  = dest_q;
                    result_d   = step_val_s;
                    ovf_d      = step_ovf_s;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // state and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            op_q       <= 3'b000;
            mcand_q    <= {(2*WIDTH){1'b0}};
            mplier_q   <= {WIDTH{1'b0}};
            acc_q      <= {(2*WIDTH){1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            dest_q     <= {ADDR_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wb_write_q <= 1'b0;
            illegal_q  <= 1'b0;
            ovf_q      <= 1'b0;
            result_q   <= {WIDTH{1'b0}};
            wb_addr_q  <= {ADDR_W{1'b0}};
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            dest_q     <= dest_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wb_write_q <= wb_write_d;
            illegal_q  <= illegal_d;
            ovf_q      <= ovf_d;
            result_q   <= result_d;
            wb_addr_q  <= wb_addr_d;
        end
    end

    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign RESULT   = result_q;
    assign WB_ADDR  = wb_addr_q;
    assign WB_WRITE = wb_write_q;
    assign OVF      = ovf_q;
    assign ILLEGAL  = illegal_q;

endmodule

// File: tb/tb_seq_exec_unit.sv
// Directed bench for seq_exec_unit: cycle-exact latency, results, flags,
// reset abort and ignored START while busy.
module tb_seq_exec_unit;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START;
    logic [2:0] OPCODE;
    logic [7:0] OPERAND1;
    logic [7:0] OPERAND2;
    logic [2:0] DEST_ADDR;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;
    logic [2:0] WB_ADDR;
    logic       WB_WRITE;
    logic       OVF;
    logic       ILLEGAL;

    int n_eval = 0;
    int n_fail = 0;

    seq_exec_unit dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .OPCODE    (OPCODE),
        .OPERAND1  (OPERAND1),
        .OPERAND2  (OPERAND2),
        .DEST_ADDR (DEST_ADDR),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .RESULT    (RESULT),
        .WB_ADDR   (WB_ADDR),
        .WB_WRITE  (WB_WRITE),
        .OVF       (OVF),
        .ILLEGAL   (ILLEGAL)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // START high in cycle c; returns in cycle c+1 with inputs scrambled
    task automatic start_op(input logic [2:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [2:0] dest);
        OPCODE    = op;
        OPERAND1  = a;
        OPERAND2  = b;
        DEST_ADDR = dest;
        START     = 1'b1;
        tick(1);
        START     = 1'b0;
        OPCODE    = 3'b010;
        OPERAND1  = 8'h5A;
        OPERAND2  = 8'hC3;
        DEST_ADDR = 3'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; START = 1'b0; OPCODE = 3'b000;
        OPERAND1 = 8'h00; OPERAND2 = 8'h00; DEST_ADDR = 3'd0;
        tick(2);
        check("rst_busy", 16'(BUSY), 16'h0);
        check("rst_done", 16'(DONE), 16'h0);
        check("rst_result", 16'(RESULT), 16'h0);
        check("rst_flags", 16'({WB_WRITE, OVF, ILLEGAL}), 16'h0);
        check("rst_wbaddr", 16'(WB_ADDR), 16'h0);
        RESET = 1'b0;
        tick(1);

        // MUL 13*11 = 143
        start_op(3'b000, 8'h0D, 8'h0B, 3'd3);
        check("mul1_busy_c1", 16'(BUSY), 16'h1);
        check("mul1_done_c1", 16'(DONE), 16'h0);
        tick(7);
        check("mul1_done_c8", 16'({DONE, WB_WRITE}), 16'h0);
        tick(1);
        check("mul1_done_c9", 16'({DONE, WB_WRITE, BUSY}), 16'h7);
        check("mul1_result", 16'(RESULT), 16'h008F);
        check("mul1_wbaddr", 16'(WB_ADDR), 16'h3);
        check("mul1_ovf_ill", 16'({OVF, ILLEGAL}), 16'h0);
        tick(1);
        check("mul1_after", 16'({DONE, WB_WRITE, BUSY}), 16'h0);
        check("mul1_held", 16'(RESULT), 16'h008F);

        // MUL 20*20 = 400 = 0x190
        start_op(3'b000, 8'h14, 8'h14, 3'd6);
        tick(8);
        check("mul2_done", 16'(DONE), 16'h1);
        check("mul2_result", 16'(RESULT), 16'h0090);
        check("mul2_ovf", 16'(OVF), 16'h1);
        check("mul2_wbaddr", 16'(WB_ADDR), 16'h6);
        tick(1);
        check("mul2_ovf_held", 16'(OVF), 16'h1);

        // SRA 0x90 by 3 -> 0xF2
        start_op(3'b011, 8'h90, 8'h03, 3'd1);
        tick(2);
        check("sra_done_c3", 16'(DONE), 16'h0);
        tick(1);
        check("sra_done_c4", 16'({DONE, WB_WRITE}), 16'h3);
        check("sra_result", 16'(RESULT), 16'h00F2);
        check("sra_ovf", 16'(OVF), 16'h0);
        check("sra_wbaddr", 16'(WB_ADDR), 16'h1);
        tick(1);

        // ROR 0x81 by 1 (upper OPERAND2 bits ignored) -> 0xC0
        start_op(3'b100, 8'h81, 8'hF9, 3'd2);
        check("ror_done_c1", 16'(DONE), 16'h0);
        tick(1);
        check("ror_done_c2", 16'(DONE), 16'h1);
        check("ror_result", 16'(RESULT), 16'h00C0);
        tick(1);

        // SRL by amount 0 retires in c+1 with value unchanged
        start_op(3'b010, 8'hF0, 8'h08, 3'd4);
        check("srl0_done_c1", 16'({DONE, WB_WRITE, BUSY}), 16'h7);
        check("srl0_result", 16'(RESULT), 16'h00F0);
        check("srl0_wbaddr", 16'(WB_ADDR), 16'h4);
        tick(1);

        // SLL 0x0F by 2 -> 0x3C
        start_op(3'b001, 8'h0F, 8'h02, 3'd5);
        tick(1);
        check("sll_done_c2", 16'(DONE), 16'h0);
        tick(1);
        check("sll_done_c3", 16'(DONE), 16'h1);
        check("sll_result", 16'(RESULT), 16'h003C);
        tick(1);

        // illegal opcode: DONE+ILLEGAL in c+1, no write, RESULT unchanged
        start_op(3'b111, 8'h12, 8'h34, 3'd7);
        check("ill_pulse", 16'({DONE, ILLEGAL, WB_WRITE, BUSY}), 16'hD);
        check("ill_result", 16'(RESULT), 16'h003C);
        tick(1);
        check("ill_after", 16'({DONE, ILLEGAL, BUSY}), 16'h0);

        // reset at c+4 of a MUL aborts it
        start_op(3'b000, 8'hFF, 8'hFF, 3'd2);
        tick(3);
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        check("abort_ctrl", 16'({BUSY, DONE, WB_WRITE, OVF, ILLEGAL}), 16'h0);
        check("abort_result", 16'(RESULT), 16'h0);
        check("abort_wbaddr", 16'(WB_ADDR), 16'h0);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("abort_no_done", 16'({DONE, WB_WRITE, BUSY}), 16'h0);
        end

        // START at c+3 while busy with different operands is ignored
        start_op(3'b000, 8'h0D, 8'h0B, 3'd3);
        tick(2);
        OPCODE = 3'b001; OPERAND1 = 8'hFF; OPERAND2 = 8'h01; DEST_ADDR = 3'd7;
        START = 1'b1;
        tick(1);
        START = 1'b0;
        tick(4);
        check("ign_done_c8", 16'(DONE), 16'h0);
        tick(1);
        check("ign_done_c9", 16'({DONE, WB_WRITE}), 16'h3);
        check("ign_result", 16'(RESULT), 16'h008F);
        check("ign_wbaddr", 16'(WB_ADDR), 16'h3);
        tick(1);
        check("ign_idle", 16'({BUSY, DONE}), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
